neuron_mac_writeback: RTL and testbench

- Data-side consumer of the address generator's read/write address streams for one network layer.
- Takes weight and neuron operands returned by the synchronous-read memories (one-cycle read latency).
- Multiply-accumulates Nk terms per neuron, then applies arithmetic shift, ReLU and saturation.
- Issues one write of the activation to neuron memory at the write address supplied alongside the terms.

---
 rtl/neuron_mac_writeback.sv | 106 ++++++++++
 tb/tb_neuron_mac_writeback.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac_writeback.sv
// neuron_mac_writeback: per-layer MAC over memory read-back operands, then shift/ReLU/saturate and write back
module neuron_mac_writeback #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int ACC_W  = 20,
    parameter int FRAC   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        Nk,
    input  logic              term_valid,
    input  logic              neuron_finished,
    input  logic              finished,
    input  logic [ADDR_W-1:0] neuro_write_addr,
    input  logic [DATA_W-1:0] weight_data,
    input  logic [DATA_W-1:0] neuro_data,
    output logic              write_en,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] write_data,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic              count_err
);
    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;
    localparam logic signed [ACC_W-1:0] MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
    state_t                   state;
    logic                     v_d, nf_d, fin_d, first;
    logic [ADDR_W-1:0]        addr_d;
    logic signed [ACC_W-1:0]  acc, sum, r;
    logic signed [2*DATA_W-1:0] prod;
    logic [7:0]               nk_lat;
    logic [8:0]               cnt, cnt_next, nk_eff;
    logic                     sat_hi;
    logic [DATA_W-1:0]        act;
    // Operands arrive one cycle after the read; fold this term into the running sum and form the activation
    always_comb begin
        prod     = $signed(weight_data) * $signed(neuro_data);
        sum      = (first ? '0 : acc) + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
        r        = sum >>> FRAC;
        sat_hi   = r > MAX;
        act      = r[ACC_W-1] ? '0 : sat_hi ? MAX[DATA_W-1:0] : r[DATA_W-1:0];
        cnt_next = first ? 9'd1 : cnt + 9'd1;
        nk_eff   = {nk_lat == 8'd0, nk_lat};
    end
    // Layer FSM, read-latency pipeline, accumulator and registered writeback
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            v_d        <= 1'b0;
            nf_d       <= 1'b0;
            fin_d      <= 1'b0;
            addr_d     <= '0;
            first      <= 1'b1;
            acc        <= '0;
            cnt        <= '0;
            nk_lat     <= '0;
            write_en   <= 1'b0;
            write_addr <= '0;
            write_data <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            count_err  <= 1'b0;
        end else begin
            write_en <= 1'b0;
            done     <= 1'b0;
            v_d      <= term_valid && state == ACCUM;
            nf_d     <= term_valid && neuron_finished && state == ACCUM;
            fin_d    <= finished && state == ACCUM;
            addr_d   <= neuro_write_addr;
            if (v_d) begin
                acc   <= sum;
                cnt   <= cnt_next;
                first <= nf_d;
                if (nf_d) begin
                    write_en   <= 1'b1;
                    write_addr <= addr_d;
                    write_data <= act;
                    if (sat_hi && !r[ACC_W-1])
                        overflow <= 1'b1;
                    if (cnt_next != nk_eff)
                        count_err <= 1'b1;
                end
            end
            case (state)
                IDLE: if (start) begin
                    state     <= ACCUM;
                    nk_lat    <= Nk;
                    overflow  <= 1'b0;
                    count_err <= 1'b0;
                    first     <= 1'b1;
                    cnt       <= '0;
                    busy      <= 1'b1;
                end
                ACCUM: if (fin_d) state <= DRAIN;
                default: begin
                    state <= IDLE;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_neuron_mac_writeback.sv
// tb_neuron_mac_writeback: scoreboard bench with an arithmetic reference model
module tb_neuron_mac_writeback;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    logic clk = 0, reset = 0, start = 0, term_valid = 0, neuron_finished = 0, finished = 0;
    logic [7:0] Nk = 0;
    logic [ADDR_W-1:0] neuro_write_addr = 0;
    logic [DATA_W-1:0] weight_data = 0, neuro_data = 0;
    logic write_en, busy, done, overflow, count_err;
    logic [ADDR_W-1:0] write_addr;
    logic [DATA_W-1:0] write_data;

    neuron_mac_writeback dut (
        .clk(clk), .reset(reset), .start(start), .Nk(Nk), .term_valid(term_valid),
        .neuron_finished(neuron_finished), .finished(finished), .neuro_write_addr(neuro_write_addr),
        .weight_data(weight_data), .neuro_data(neuro_data), .write_en(write_en),
        .write_addr(write_addr), .write_data(write_data), .busy(busy), .done(done),
        .overflow(overflow), .count_err(count_err)
    );

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0, miscompares = 0;
    typedef struct {int addr; int data; int at;} wr_t;
    wr_t wq[$];
    int dq[$];
    int tw[$], tx[$], taddr[$];
    bit tnf[$], tfin[$];
    bit exp_ov, exp_ce;
    wr_t me;
    int md;

    task automatic check(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // monitor: every write and done pulse must match the head of its queue
    always @(negedge clk) if (reset) begin
        if (write_en) begin
            if (wq.size() == 0) check("unexpected write", 1, 0);
            else begin
                me = wq.pop_front();
                check("write addr", int'(write_addr), me.addr);
                check("write data", int'(write_data), me.data);
                check("write cycle", cyc, me.at);
            end
        end
        if (done) begin
            if (dq.size() == 0) check("unexpected done", 1, 0);
            else begin
                md = dq.pop_front();
                check("done cycle", cyc, md);
            end
        end
    end

    task automatic add_term(input int w, input int x, input bit nf, input bit fin, input int addr);
        tw.push_back(w); tx.push_back(x); tnf.push_back(nf); tfin.push_back(fin); taddr.push_back(addr);
    endtask

    task automatic run_layer(input int nk, input bit gaps);
        int nk_eff, pw, px, sum, cnt, r, k, guard;
        bit first;
        nk_eff = nk == 0 ? 256 : nk;
        pw = 0; px = 0; sum = 0; cnt = 0; k = 0; first = 1;
        exp_ov = 0; exp_ce = 0;
        @(negedge clk); start = 1; Nk = nk[7:0];
        @(negedge clk); start = 0;
        check("busy after start", busy, 1);
        check("overflow cleared", overflow, 0);
        check("count_err cleared", count_err, 0);
        while (k < tw.size()) begin
            weight_data = pw[7:0]; neuro_data = px[7:0];
            if (gaps && $urandom_range(0, 3) == 0) begin
                term_valid = 0; neuron_finished = 1'($urandom); finished = 0;
                neuro_write_addr = 8'($urandom); pw = int'($urandom); px = int'($urandom);
            end else begin
                term_valid = 1; neuron_finished = tnf[k]; finished = tfin[k];
                neuro_write_addr = taddr[k][7:0]; pw = tw[k]; px = tx[k];
                if (first) begin sum = 0; cnt = 0; end
                sum += tw[k] * tx[k];
                cnt++;
                first = 0;
                if (tnf[k]) begin
                    r = sum >>> 4;
                    if (r < 0) r = 0;
                    else if (r > 127) begin r = 127; exp_ov = 1; end
                    if (cnt != nk_eff) exp_ce = 1;
                    wq.push_back('{taddr[k], r, cyc + 2});
                    first = 1;
                end
                if (tfin[k]) dq.push_back(cyc + 3);
                k++;
            end
            @(negedge clk);
        end
        weight_data = pw[7:0]; neuro_data = px[7:0];
        term_valid = 0; neuron_finished = 0; finished = 0;
        guard = 0;
        while ((wq.size() != 0 || dq.size() != 0) && guard < 50) begin
            @(negedge clk); #1; guard++;
        end
        check("pending after drain", wq.size() + dq.size(), 0);
        check("busy after done", busy, 0);
        check("overflow", overflow, int'(exp_ov));
        check("count_err", count_err, int'(exp_ce));
        tw.delete(); tx.delete(); tnf.delete(); tfin.delete(); taddr.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int nk, nn, nt;
        repeat (2) @(negedge clk);
        check("reset write_en", write_en, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset overflow", overflow, 0);
        check("reset count_err", count_err, 0);
        reset = 1;
        // basic neuron: 1.0 + 2.0 - 1.0 = 2.0 -> 32
        add_term(16, 16, 0, 0, 3); add_term(32, 16, 0, 0, 3); add_term(-16, 16, 1, 1, 3);
        run_layer(3, 0);
        // ReLU clamps the negative sum
        add_term(-32, 16, 0, 0, 5); add_term(16, 16, 1, 1, 5);
        run_layer(2, 0);
        // saturation, overflow must stay sticky
        repeat (3) add_term(127, 127, 0, 0, 7);
        add_term(127, 127, 1, 1, 7);
        run_layer(4, 0);
        repeat (3) @(negedge clk);
        check("overflow sticky", overflow, 1);
        // back-to-back neurons
        add_term(16, 16, 0, 0, 10); add_term(16, 16, 1, 0, 10);
        add_term(48, 16, 0, 0, 11); add_term(0, 0, 1, 1, 11);
        run_layer(2, 0);
        // short neuron flags count_err but still writes
        add_term(20, 30, 0, 0, 12); add_term(-50, 9, 0, 0, 12); add_term(70, 11, 1, 1, 12);
        run_layer(4, 0);
        // reset while a result is pending
        @(negedge clk); start = 1; Nk = 1;
        @(negedge clk); start = 0; term_valid = 1; neuron_finished = 1; finished = 1; neuro_write_addr = 9;
        @(negedge clk); term_valid = 0; neuron_finished = 0; finished = 0;
        weight_data = 8'd16; neuro_data = 8'd16; reset = 0;
        @(negedge clk);
        check("abort write_en", write_en, 0);
        check("abort write_addr", int'(write_addr), 0);
        check("abort write_data", int'(write_data), 0);
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort overflow", overflow, 0);
        check("abort count_err", count_err, 0);
        reset = 1;
        repeat (4) @(negedge clk);
        check("no done after abort", done, 0);
        add_term(16, 16, 0, 0, 3); add_term(32, 16, 0, 0, 3); add_term(-16, 16, 1, 1, 3);
        run_layer(3, 0);
        // Nk = 0 means 256 terms
        for (int i = 0; i < 256; i++)
            add_term($urandom_range(0, 6) - 3, $urandom_range(0, 6) - 3, i == 255, i == 255, 44);
        run_layer(0, 0);
        // randomized layers with bubbles and occasional term-count mismatches
        for (int l = 0; l < 25; l++) begin
            nk = $urandom_range(1, 6);
            nn = $urandom_range(1, 4);
            for (int n = 0; n < nn; n++) begin
                nt = nk;
                if ($urandom_range(0, 9) == 0) nt = (nk > 1 && $urandom_range(0, 1) == 1) ? nk - 1 : nk + 1;
                for (int t = 0; t < nt; t++)
                    add_term($urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
                             t == nt - 1, t == nt - 1 && n == nn - 1, $urandom_range(0, 255));
            end
            run_layer(nk, 1);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
